coin_acceptor: RTL and testbench



---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_acceptor_sync2.sv | 26 ++
 rtl/coin_acceptor.sv | 139 +++++++++++++
 tb/tb_coin_acceptor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor FSM encoding, used by the coin acceptor
// and by the downstream credit and dispense logic.
package coin_pkg;

    localparam logic [2:0] COIN_NONE = 3'd0;
    localparam logic [2:0] COIN_25   = 3'd1;
    localparam logic [2:0] COIN_50   = 3'd2;
    localparam logic [2:0] COIN_100  = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        ARM          = 3'd2,
        PULSE        = 3'd3,
        WAIT_RELEASE = 3'd4
    } coin_state_e;

    // A valid insertion has exactly one line high.
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
    endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin input synchroniser, debouncer and single-event qualifier.
// Define COIN_STATS_EN to add saturating per-coin acceptance counters.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] coin_btn,
    output logic [2:0] coin,
    output logic       got_coin,
    output logic       coin_reject,
    output logic       busy
`ifdef COIN_STATS_EN
    ,
    output logic [7:0] cnt_25,
    output logic [7:0] cnt_50,
    output logic [7:0] cnt_100
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync;
    coin_state_e      state_q, state_d;
    logic [2:0]       sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       coin_q, coin_d;
    logic             got_q, got_d;
    logic             reject_q, reject_d;

    sync2 #(.W(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (coin_btn),
        .q_o   (sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= 3'd0;
            cnt_q    <= '0;
            coin_q   <= COIN_NONE;
            got_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            coin_q   <= coin_d;
            got_q    <= got_d;
            reject_q <= reject_d;
        end
    end

    // Downstream samples coin on the rising edge of got_coin: coin is loaded
    // in ARM, one full cycle before the strobe, and held until after release.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        coin_d   = coin_q;
        got_d    = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                coin_d = COIN_NONE;
                if (sync != 3'd0) begin
                    sample_d = sync;
                    cnt_d    = '0;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync != sample_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (is_one_hot(sample_q)) begin
                        coin_d  = sample_q;
                        state_d = ARM;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = WAIT_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARM: begin
                got_d   = 1'b1;
                state_d = PULSE;
            end
            PULSE: begin
                cnt_d   = '0;
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (sync != 3'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign coin        = coin_q;
    assign got_coin    = got_q;
    assign coin_reject = reject_q;
    assign busy        = (state_q != IDLE);

`ifdef COIN_STATS_EN
    logic [7:0] cnt_25_q, cnt_50_q, cnt_100_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_25_q  <= 8'd0;
            cnt_50_q  <= 8'd0;
            cnt_100_q <= 8'd0;
        end else if (state_q == PULSE) begin
            if (coin_q == COIN_25 && cnt_25_q != 8'hFF) cnt_25_q <= cnt_25_q + 8'd1;
            if (coin_q == COIN_50 && cnt_50_q != 8'hFF) cnt_50_q <= cnt_50_q + 8'd1;
            if (coin_q == COIN_100 && cnt_100_q != 8'hFF) cnt_100_q <= cnt_100_q + 8'd1;
        end
    end

    assign cnt_25  = cnt_25_q;
    assign cnt_50  = cnt_50_q;
    assign cnt_100 = cnt_100_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int DEB = 4;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] coin_btn = 3'd0;
    logic [2:0] coin;
    logic       got_coin;
    logic       coin_reject;
    logic       busy;
`ifdef COIN_STATS_EN
    logic [7:0] cnt_25, cnt_50, cnt_100;
`endif

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_btn    (coin_btn),
        .coin        (coin),
        .got_coin    (got_coin),
        .coin_reject (coin_reject),
        .busy        (busy)
`ifdef COIN_STATS_EN
        ,
        .cnt_25      (cnt_25),
        .cnt_50      (cnt_50),
        .cnt_100     (cnt_100)
`endif
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset_now();
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        coin_btn = 3'd0;
        tick(2);
        #2 reset = 1'b0;
        tick(2);
    endtask

    // scoreboard: expected coin code for each got_coin strobe
    logic [2:0] exp_q[$];
    logic [2:0] exp_coin;
    logic [2:0] prev_coin = 3'd0;
    int got_cnt = 0;
    int rej_cnt = 0;
    int coin_nz_cycles = 0;
    int run_len = 0;

    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            prev_coin = 3'd0;
        end else begin
            if (got_coin) begin
                if (run_len == 0) begin
                    got_cnt++;
                    if (exp_q.size() == 0) begin
                        check("got_unexpected", int'(coin), int'(COIN_NONE));
                    end else begin
                        exp_coin = exp_q.pop_front();
                        check("got_coin_code", int'(coin), int'(exp_coin));
                        check("coin_setup", int'(prev_coin), int'(exp_coin));
                    end
                end
                run_len++;
            end else if (run_len != 0) begin
                check("got_width", run_len, 1);
                run_len = 0;
            end
            if (coin_reject) rej_cnt++;
            if (coin != COIN_NONE) coin_nz_cycles++;
            prev_coin = coin;
        end
    end

    int g0, r0, n0;

    initial begin
        tick(2);
        check("rst_coin", int'(coin), 0);
        check("rst_got", int'(got_coin), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_busy", int'(busy), 0);
        #2 reset = 1'b0;
        tick(3);

        // reset asserted mid-DEBOUNCE
        coin_btn = 3'b001;
        tick(4);
        check("busy_debounce", int'(busy), 1);
        pulse_reset_now();
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_coin", int'(coin), 0);
        check("async_rst_got", int'(got_coin), 0);
        release_reset();
        check("idle_after_rst", int'(busy), 0);

        // stable 25c press held 20 cycles
        g0 = got_cnt;
        coin_btn = 3'b001;
        exp_q.push_back(COIN_25);
        tick(7);
        check("coin_before_got", int'(coin), int'(COIN_25));
        check("got_low_in_arm", int'(got_coin), 0);
        tick(1);
        check("got_at_8", int'(got_coin), 1);
        tick(1);
        check("got_one_cycle", int'(got_coin), 0);
        tick(11);
        check("single_got_held", got_cnt - g0, 1);
        coin_btn = 3'b000;
        tick(5);
        check("coin_held_release", int'(coin), int'(COIN_25));
        check("busy_release", int'(busy), 1);
        tick(2);
        check("coin_cleared", int'(coin), 0);
        check("idle_after_release", int'(busy), 0);

        // R$1 line bouncing, then stable
        g0 = got_cnt;
        for (int i = 0; i < 6; i++) begin
            coin_btn = (i % 2 == 0) ? 3'b100 : 3'b000;
            tick(2);
        end
        check("no_got_bounce", got_cnt - g0, 0);
        coin_btn = 3'b100;
        exp_q.push_back(COIN_100);
        tick(20);
        check("got_after_stable", got_cnt - g0, 1);
        coin_btn = 3'b000;
        tick(10);
        check("idle_after_bounce", int'(busy), 0);

        // two lines at once
        g0 = got_cnt;
        r0 = rej_cnt;
        n0 = coin_nz_cycles;
        coin_btn = 3'b011;
        tick(7);
        check("reject_strobe", int'(coin_reject), 1);
        tick(13);
        coin_btn = 3'b000;
        tick(10);
        check("reject_once", rej_cnt - r0, 1);
        check("no_got_multi", got_cnt - g0, 0);
        check("coin_zero_multi", coin_nz_cycles - n0, 0);
        check("idle_after_multi", int'(busy), 0);

        // short release does not rearm; full release does
        g0 = got_cnt;
        coin_btn = 3'b010;
        exp_q.push_back(COIN_50);
        tick(12);
        coin_btn = 3'b000;
        tick(2);
        coin_btn = 3'b010;
        tick(12);
        check("short_gap_one_got", got_cnt - g0, 1);
        coin_btn = 3'b000;
        tick(10);
        coin_btn = 3'b010;
        exp_q.push_back(COIN_50);
        tick(12);
        check("full_gap_two_got", got_cnt - g0, 2);
        coin_btn = 3'b000;
        tick(10);

        // reset truncates a pulse in progress
        coin_btn = 3'b001;
        exp_q.push_back(COIN_25);
        tick(8);
        check("got_before_trunc", int'(got_coin), 1);
        pulse_reset_now();
        check("trunc_got", int'(got_coin), 0);
        check("trunc_coin", int'(coin), 0);
        check("trunc_busy", int'(busy), 0);
        release_reset();

`ifdef COIN_STATS_EN
        check("stats_rst_25", int'(cnt_25), 0);
        for (int i = 0; i < 300; i++) begin
            coin_btn = 3'b001;
            exp_q.push_back(COIN_25);
            tick(10);
            coin_btn = 3'b000;
            tick(8);
            if (i == 9) check("stats_10", int'(cnt_25), 10);
        end
        check("stats_sat_25", int'(cnt_25), 255);
        check("stats_50", int'(cnt_50), 0);
        check("stats_100", int'(cnt_100), 0);
`endif

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
